// File: rtl/wb_line_reader_if.sv
// Pipelined Wishbone bus bundle used between the line reader
// and the SDRAM controller. master drives the request side.
interface if_wb #(
    parameter int AWIDTH = 26
) ();
    logic              cyc;
    logic              stb;
    logic              we;
    logic [AWIDTH-1:0] adr;
    logic [3:0]        sel;
    logic [31:0]       dat_o;
    logic [31:0]       dat_i;
    logic              ack;
    logic              stall;

    modport master (
        output cyc, stb, we, adr, sel, dat_o,
        input  dat_i, ack, stall
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_o,
        output dat_i, ack, stall
    );
endinterface

// File: rtl/wb_line_reader.sv
// Burst line reader: issues pipelined Wishbone reads and queues
// returned words in a show-ahead FIFO with credit-based flow control.
//
// Ports:
//   clk_i, rst_i          clock, async active-low reset
//   start/base_adr/count  transfer request (sampled when idle)
//   busy, done            transfer status, done is a 1-cycle pulse
//   bus                   pipelined Wishbone master
//   out_data/out_valid/
//   out_ready             show-ahead word stream to the consumer
module wb_line_reader #(
    parameter int AWIDTH = 26,
    parameter int DEPTH  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start,
    input  logic [AWIDTH-1:0] base_adr,
    input  logic [15:0]       count,
    output logic              busy,
    output logic              done,
    if_wb.master              bus,
    output logic [31:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [AWIDTH-1:0] r_adr;
    logic [15:0]       r_rem;
    logic [CW-1:0]     r_out;
    logic [CW-1:0]     r_occ;
    logic [PW-1:0]     r_wp;
    logic [PW-1:0]     r_rp;
    logic [31:0]       r_mem [DEPTH];
    logic              r_done;
    // set once the first request of a transfer has been
    // presented; keeps cyc up while credit throttles stb
    logic              r_act;

    logic          w_stb;
    logic          w_cyc;
    logic          w_busy;
    logic          w_accept;
    logic          w_issue;
    logic          w_ack;
    logic          w_push;
    logic          w_pop;
    logic          w_last;
    logic          w_final;
    logic          w_credit;
    logic [CW:0]   w_used;
    logic          w_unused;

    // word addressing: the byte lane bits are not used
    assign w_unused = &{1'b0, base_adr[1:0]};

    // a start in the done cycle is still "while busy"
    assign w_accept = start & (r_state == IDLE) & ~r_done;

    // in-flight requests plus buffered words must fit the FIFO
    assign w_used   = {1'b0, r_out} + {1'b0, r_occ};
    assign w_credit = w_used < (CW + 1)'(DEPTH);

    assign w_issue = w_stb & ~bus.stall;

    // acks with nothing outstanding are stray and dropped
    assign w_ack   = bus.ack & (r_out != '0);

    assign w_pop   = out_ready & (r_occ != '0);
    assign w_push  = w_ack & ((r_occ != CW'(DEPTH)) | w_pop);

    assign w_last  = w_issue & (r_rem == 16'd1);
    assign w_final = (r_state == DRAIN) & w_ack
                   & (r_out == CW'(1));

    // state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept && count != 16'd0) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_final) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // output logic
    always_comb begin
        w_stb  = 1'b0;
        w_cyc  = 1'b0;
        w_busy = r_done;
        unique case (r_state)
            IDLE: begin
                w_stb = 1'b0;
            end
            RUN: begin
                w_stb  = (r_rem != 16'd0) & w_credit;
                w_cyc  = w_stb | r_act;
                w_busy = 1'b1;
            end
            DRAIN: begin
                w_cyc  = 1'b1;
                w_busy = 1'b1;
            end
            default: begin
                w_stb = 1'b0;
            end
        endcase
    end

    // request address, word counters and status
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_adr  <= '0;
            r_rem  <= '0;
            r_out  <= '0;
            r_done <= 1'b0;
            r_act  <= 1'b0;
        end else begin
            r_done <= (w_accept & (count == 16'd0))
                    | w_final;

            if (w_accept) begin
                r_adr <= {base_adr[AWIDTH-1:2], 2'b00};
                r_rem <= count;
            end else if (w_issue) begin
                r_adr <= r_adr + AWIDTH'(4);
                r_rem <= r_rem - 16'd1;
            end

            if (r_state == IDLE) begin
                r_act <= 1'b0;
            end else if (w_stb) begin
                r_act <= 1'b1;
            end

            r_out <= r_out + CW'(w_issue) - CW'(w_ack);
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_occ <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + PW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + PW'(1);
            end
            r_occ <= r_occ + CW'(w_push) - CW'(w_pop);
        end
    end

    // FIFO storage, contents are don't-care while empty
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wp] <= bus.dat_i;
        end
    end

    assign out_data  = r_mem[r_rp];
    assign out_valid = (r_occ != '0);

    assign busy = w_busy;
    assign done = r_done;

    assign bus.cyc   = w_cyc;
    assign bus.stb   = w_stb;
    assign bus.we    = 1'b0;
    assign bus.adr   = r_adr;
    assign bus.sel   = 4'hf;
    assign bus.dat_o = 32'h0;
endmodule

// File: tb/tb_wb_line_reader.sv
// Bench for wb_line_reader: random Wishbone slave, random consumer,
// queue-based reference model checked every cycle.
module tb_wb_line_reader;
    localparam int AW    = 26;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base;
    logic [15:0]   cnt;
    logic          busy;
    logic          done;
    logic [31:0]   out_data;
    logic          out_valid;
    logic          out_ready;

    if_wb #(.AWIDTH(AW)) wb ();

    always #5 clk = ~clk;

    wb_line_reader #(.AWIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk_i     (clk),
        .rst_i     (rst_n),
        .start     (start),
        .base_adr  (base),
        .count     (cnt),
        .busy      (busy),
        .done      (done),
        .bus       (wb),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct {
        int          due;
        logic [31:0] d;
    } pend_t;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    pend_t         pend[$];
    int            last_due = 0;
    logic [31:0]   mbuf[$];
    logic [AW-1:0] issued[$];
    logic [AW-1:0] exp_adr;

    bit m_busy, m_done, m_run, m_cyc;
    int m_rem, m_out;

    int n_done, done_cyc, start_cyc, first_stb_cyc;
    int cyc_seen, n_pop;
    int stall_pct, rdy_pct, lat_min, lat_max;

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d",
                     nm, act, exp, cyc_n);
        end
    endtask

    // model of what the next rising edge does, plus checks of
    // the outputs as they stand in this cycle
    task automatic sample();
        bit    exp_stb, exp_cyc, fin, nd, was_busy;
        int    due;
        pend_t e;
        if (!rst_n) begin
            chk("rst_cyc",   64'(wb.cyc),    64'(0));
            chk("rst_stb",   64'(wb.stb),    64'(0));
            chk("rst_adr",   64'(wb.adr),    64'(0));
            chk("rst_busy",  64'(busy),      64'(0));
            chk("rst_done",  64'(done),      64'(0));
            chk("rst_valid", 64'(out_valid), 64'(0));
            m_busy = 0; m_done = 0; m_run = 0; m_cyc = 0;
            m_rem = 0; m_out = 0;
            mbuf.delete();
            return;
        end
        exp_stb = m_run && (m_rem > 0)
                  && ((m_out + mbuf.size()) < DEPTH);
        exp_cyc = m_cyc || exp_stb;
        chk("busy",  64'(busy),      64'(m_busy));
        chk("done",  64'(done),      64'(m_done));
        chk("stb",   64'(wb.stb),    64'(exp_stb));
        chk("cyc",   64'(wb.cyc),    64'(exp_cyc));
        chk("valid", 64'(out_valid), 64'(mbuf.size() != 0));
        if (mbuf.size() != 0)
            chk("data", 64'(out_data), 64'(mbuf[0]));
        if (wb.stb) begin
            chk("adr", 64'(wb.adr), 64'(exp_adr));
            chk("ctl", 64'({wb.we, wb.sel, wb.dat_o}),
                64'({1'b0, 4'hf, 32'h0}));
            if (first_stb_cyc < 0) first_stb_cyc = cyc_n;
        end
        if (wb.cyc) cyc_seen++;
        if (done) begin
            n_done++;
            done_cyc = cyc_n;
        end
        // slave: accept the request, schedule its in-order ack
        if (wb.cyc && wb.stb && !wb.stall) begin
            due = cyc_n + $urandom_range(lat_min, lat_max);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            e.due = due;
            e.d   = $urandom;
            pend.push_back(e);
            issued.push_back(wb.adr);
        end
        // consumer pops the word visible now
        if (out_ready && mbuf.size() != 0) begin
            void'(mbuf.pop_front());
            n_pop++;
        end
        fin = 0;
        if (wb.ack && m_out > 0) begin
            m_out--;
            mbuf.push_back(wb.dat_i);
            fin = (m_rem == 0) && (m_out == 0);
        end
        if (exp_stb) m_cyc = 1;
        if (exp_stb && !wb.stall) begin
            m_rem--;
            m_out++;
            exp_adr = exp_adr + 26'd4;
        end
        nd = fin;
        was_busy = m_busy;
        if (m_done) begin
            m_busy = 0;
            m_run  = 0;
        end
        if (fin) begin
            m_run = 0;
            m_cyc = 0;
        end
        if (start && !was_busy) begin
            m_busy    = 1;
            start_cyc = cyc_n;
            if (cnt == 16'd0) begin
                nd = 1;
            end else begin
                m_run   = 1;
                m_cyc   = 0;
                m_rem   = int'(cnt);
                exp_adr = {base[AW-1:2], 2'b00};
            end
        end
        m_done = nd;
    endtask

    // one clock cycle, entered and left just after a falling edge
    task automatic step();
        wb.stall = ($urandom_range(0, 99) < stall_pct);
        if (rst_n && pend.size() != 0 && pend[0].due <= cyc_n) begin
            wb.ack   = 1'b1;
            wb.dat_i = pend[0].d;
            void'(pend.pop_front());
        end else begin
            wb.ack   = 1'b0;
            wb.dat_i = $urandom;
        end
        out_ready = ($urandom_range(0, 99) < rdy_pct);
        #1;
        sample();
        @(negedge clk);
        cyc_n++;
        start = 1'b0;
    endtask

    task automatic begin_xfer(input logic [AW-1:0] b, input int n);
        base  = b;
        cnt   = 16'(n);
        start = 1'b1;
        issued.delete();
        n_done = 0; cyc_seen = 0; n_pop = 0;
        first_stb_cyc = -1; done_cyc = -1;
        step();
    endtask

    task automatic finish_xfer(input int budget, input bit poke);
        int k;
        k = 0;
        while ((m_busy || mbuf.size() != 0 || pend.size() != 0)
               && k < budget) begin
            if (poke && k == 3 && m_busy) begin
                start = 1'b1;
                base  = 26'h1234560;
                cnt   = 16'd7;
            end
            step();
            k++;
        end
        chk("xfer_timeout", 64'(k < budget), 64'(1));
    endtask

    logic [AW-1:0] e029 [4];
    logic [AW-1:0] e032 [4];

    initial begin
        e029 = '{26'h100, 26'h104, 26'h108, 26'h10C};
        e032 = '{26'h3FFFFF8, 26'h3FFFFFC, 26'h0, 26'h4};
        rst_n = 1'b0; start = 1'b0; base = '0; cnt = '0;
        out_ready = 1'b0;
        wb.ack = 1'b0; wb.stall = 1'b0; wb.dat_i = '0;
        stall_pct = 0; rdy_pct = 100; lat_min = 2; lat_max = 2;
        m_busy = 0; m_done = 0; m_run = 0; m_cyc = 0;
        m_rem = 0; m_out = 0; exp_adr = '0;
        @(negedge clk);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();

        // basic burst, fixed ack latency of two cycles
        begin_xfer(26'h100, 4);
        finish_xfer(100, 0);
        chk("t1_n", 64'(issued.size()), 64'(4));
        for (int i = 0; i < 4 && i < issued.size(); i++)
            chk("t1_adr", 64'(issued[i]), 64'(e029[i]));
        chk("t1_done", 64'(n_done), 64'(1));
        chk("t1_pop", 64'(n_pop), 64'(4));
        chk("t1_lat", 64'(first_stb_cyc), 64'(start_cyc + 1));

        // address wrap at the top of the space
        begin_xfer(26'h3FFFFF8, 4);
        finish_xfer(100, 0);
        chk("t2_n", 64'(issued.size()), 64'(4));
        for (int i = 0; i < 4 && i < issued.size(); i++)
            chk("t2_adr", 64'(issued[i]), 64'(e032[i]));

        // zero-length request
        repeat (2) step();
        begin_xfer(26'h40, 0);
        finish_xfer(20, 0);
        chk("t3_done", 64'(n_done), 64'(1));
        chk("t3_dcyc", 64'(done_cyc), 64'(start_cyc + 1));
        chk("t3_cyc", 64'(cyc_seen), 64'(0));

        // consumer blocked: credit stops at buffer depth
        rdy_pct = 0; lat_min = 1; lat_max = 3;
        begin_xfer(26'h2000, 40);
        repeat (40) step();
        chk("t4_cap", 64'(issued.size()), 64'(16));
        chk("t4_stb", 64'(wb.stb), 64'(0));
        chk("t4_valid", 64'(out_valid), 64'(1));
        rdy_pct = 100;
        finish_xfer(400, 0);
        chk("t4_n", 64'(issued.size()), 64'(40));
        chk("t4_pop", 64'(n_pop), 64'(40));

        // random stall, latency and consumer, start while busy
        stall_pct = 50; rdy_pct = 70; lat_min = 1; lat_max = 4;
        for (int t = 0; t < 6; t++) begin
            int n;
            logic [AW-1:0] b;
            n = $urandom_range(1, 30);
            b = AW'($urandom);
            begin_xfer(b, n);
            finish_xfer(1500, 1);
            chk("t5_n", 64'(issued.size()), 64'(n));
            chk("t5_done", 64'(n_done), 64'(1));
            if (issued.size() != 0)
                chk("t5_last", 64'(issued[issued.size() - 1]),
                    64'(AW'({b[AW-1:2], 2'b00} + AW'(4 * (n - 1)))));
        end

        // reset in the middle of a transfer
        stall_pct = 0; rdy_pct = 100; lat_min = 3; lat_max = 3;
        begin_xfer(26'h500, 8);
        begin
            int k;
            k = 0;
            while (issued.size() < 3 && k < 20) begin
                step();
                k++;
            end
            chk("t6_wait", 64'(k < 20), 64'(1));
        end
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        begin
            int k;
            k = 0;
            while (pend.size() != 0 && k < 20) begin
                step();
                k++;
            end
            chk("t6_stale", 64'(k < 20), 64'(1));
        end
        chk("t6_empty", 64'(out_valid), 64'(0));
        begin_xfer(26'h600, 5);
        finish_xfer(100, 0);
        chk("t6_n", 64'(issued.size()), 64'(5));
        chk("t6_done", 64'(n_done), 64'(1));
        chk("t6_pop", 64'(n_pop), 64'(5));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
